// File: rtl/door_scheduler_if.sv
// Candidate-in / result-out handshake bundle for the door scheduler.
// The master side feeds candidates and consumes results; the slave side is the scheduler.
interface door_scheduler_if;
    logic       in_valid;
    logic       in_ready;
    logic [4:0] doraemon_id;
    logic [7:0] size;
    logic [7:0] iq_score;
    logic [7:0] eq_score;
    logic [2:0] size_weight;
    logic [2:0] iq_weight;
    logic [2:0] eq_weight;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] out_data;
    logic       busy;

    modport master (
        output in_valid, doraemon_id, size, iq_score, eq_score,
               size_weight, iq_weight, eq_weight, out_ready,
        input  in_ready, out_valid, out_data, busy
    );

    modport slave (
        input  in_valid, doraemon_id, size, iq_score, eq_score,
               size_weight, iq_weight, eq_weight, out_ready,
        output in_ready, out_valid, out_data, busy
    );
endinterface

// File: rtl/door_scheduler.sv
// Five-slot weighted-score scheduler: fills five doors, scans them one per cycle for
// the highest score (ties go to the lowest door), emits the winner, then refills that door.
module door_scheduler (
    input  logic            clk,
    input  logic            rst,
    door_scheduler_if.slave bus
);
    typedef enum logic [1:0] {FILL, EVAL, EMIT, REFILL} state_t;

    typedef struct packed {
        logic [4:0] id;
        logic [7:0] size;
        logic [7:0] iq;
        logic [7:0] eq;
    } slot_t;

    state_t      state;
    slot_t       slot [5];
    logic [2:0]  w_size, w_iq, w_eq;
    logic [2:0]  fill_cnt, eval_cnt, win;
    logic [12:0] max_score;
    logic        in_ready_q, out_valid_q;
    logic [7:0]  out_data_q;

    logic        accept;
    slot_t       cand;
    logic [12:0] cur_score;
    logic        cur_wins;
    logic [2:0]  final_win;

    // 13 bits holds 3 * 255 * 7 = 5355 exactly.
    function automatic logic [12:0] score_of(input slot_t s, input logic [2:0] ws,
                                             input logic [2:0] wi, input logic [2:0] we);
        return 13'(s.size) * 13'(ws) + 13'(s.iq) * 13'(wi) + 13'(s.eq) * 13'(we);
    endfunction

    assign accept = bus.in_valid && in_ready_q;
    assign cand   = {bus.doraemon_id, bus.size, bus.iq_score, bus.eq_score};

    always_comb begin
        // NOTE: every always_comb output gets a default first so no path can infer a latch.
        cur_score = '0;
        cur_wins  = 1'b0;
        final_win = win;
        cur_score = score_of(slot[eval_cnt], w_size, w_iq, w_eq);
        cur_wins  = (eval_cnt == 3'd0) || (cur_score > max_score);
        if (cur_wins) final_win = eval_cnt;
    end

    // NOTE: state uses <= only, so every branch below reads pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= FILL;
            fill_cnt    <= '0;
            eval_cnt    <= '0;
            win         <= '0;
            max_score   <= '0;
            in_ready_q  <= 1'b0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            w_size      <= '0;
            w_iq        <= '0;
            w_eq        <= '0;
            // NOTE: the slot array is small and must read as zero after reset, so it is reset like any flop.
            for (int i = 0; i < 5; i++) slot[i] <= '0;
        end else begin
            case (state)
                FILL: begin
                    in_ready_q <= 1'b1;
                    if (accept) begin
                        slot[fill_cnt] <= cand;
                        if (fill_cnt == 3'd4) begin
                            w_size     <= bus.size_weight;
                            w_iq       <= bus.iq_weight;
                            w_eq       <= bus.eq_weight;
                            eval_cnt   <= '0;
                            in_ready_q <= 1'b0;
                            state      <= EVAL;
                        end else begin
                            fill_cnt <= fill_cnt + 3'd1;
                        end
                    end
                end
                EVAL: begin
                    if (cur_wins) begin
                        max_score <= cur_score;
                        win       <= eval_cnt;
                    end
                    if (eval_cnt == 3'd4) begin
                        out_valid_q <= 1'b1;
                        out_data_q  <= {final_win, slot[final_win].id};
                        state       <= EMIT;
                    end else begin
                        eval_cnt <= eval_cnt + 3'd1;
                    end
                end
                EMIT: begin
                    if (bus.out_ready) begin
                        out_valid_q <= 1'b0;
                        in_ready_q  <= 1'b1;
                        state       <= REFILL;
                    end
                end
                REFILL: begin
                    if (accept) begin
                        slot[win]  <= cand;
                        w_size     <= bus.size_weight;
                        w_iq       <= bus.iq_weight;
                        w_eq       <= bus.eq_weight;
                        eval_cnt   <= '0;
                        in_ready_q <= 1'b0;
                        state      <= EVAL;
                    end
                end
                default: state <= FILL;
            endcase
        end
    end

    assign bus.in_ready  = in_ready_q;
    assign bus.out_valid = out_valid_q;
    assign bus.out_data  = out_data_q;
    assign bus.busy      = (state != FILL);
endmodule

// File: tb/tb_door_scheduler.sv
// Self-checking bench for door_scheduler: directed vector table, multi-cycle corner
// sequences, and randomized refills compared against a slot/argmax reference model.
module tb_door_scheduler;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    door_scheduler_if bus();
    door_scheduler dut (.clk(clk), .rst(rst), .bus(bus.slave));

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
        end
    endtask

    // Reference model: plain arrays of door contents and an argmax over weighted sums.
    int m_id[5], m_sz[5], m_iq[5], m_eq[5], m_w[3];
    int m_fill, m_win;

    function automatic void model_reset();
        for (int i = 0; i < 5; i++) begin
            m_id[i] = 0; m_sz[i] = 0; m_iq[i] = 0; m_eq[i] = 0;
        end
        for (int i = 0; i < 3; i++) m_w[i] = 0;
        m_fill = 0;
        m_win  = 0;
    endfunction

    function automatic int model_pick();
        int best = -1;
        int pick = 0;
        for (int i = 0; i < 5; i++) begin
            int s = m_sz[i] * m_w[0] + m_iq[i] * m_w[1] + m_eq[i] * m_w[2];
            if (s > best) begin best = s; pick = i; end
        end
        return pick;
    endfunction

    function automatic logic [7:0] model_data();
        int p = model_pick();
        return 8'(p * 32 + m_id[p]);
    endfunction

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b0;
        #1;
        check("rst_out_valid", bus.out_valid, 0);
        check("rst_in_ready",  bus.in_ready,  0);
        check("rst_busy",      bus.busy,      0);
        check("rst_out_data",  bus.out_data,  0);
        @(negedge clk);
        rst = 1'b0;
        model_reset();
        @(posedge clk); #1;
        check("post_rst_in_ready", bus.in_ready, 1);
    endtask

    task automatic send(input int id, input int sz, input int iq, input int eq,
                        input int ws, input int wi, input int we);
        int n = 0;
        int idx;
        @(negedge clk);
        bus.doraemon_id = 5'(id);
        bus.size        = 8'(sz);
        bus.iq_score    = 8'(iq);
        bus.eq_score    = 8'(eq);
        bus.size_weight = 3'(ws);
        bus.iq_weight   = 3'(wi);
        bus.eq_weight   = 3'(we);
        bus.in_valid    = 1'b1;
        while (!bus.in_ready && n < 50) begin @(negedge clk); n++; end
        if (n >= 50) begin
            check("send_timeout", 0, 1);
            bus.in_valid = 1'b0;
            return;
        end
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        idx = (m_fill < 5) ? m_fill : m_win;
        m_id[idx] = id; m_sz[idx] = sz; m_iq[idx] = iq; m_eq[idx] = eq;
        if (m_fill >= 4) begin m_w[0] = ws; m_w[1] = wi; m_w[2] = we; end
        if (m_fill < 5) m_fill++;
    endtask

    // Called right after the accepting edge; result must appear on the 5th edge.
    task automatic wait_result(input string name, input logic [7:0] exp);
        int lat = 0;
        while (!bus.out_valid && lat < 30) begin @(posedge clk); #1; lat++; end
        check({name, "_latency"}, lat, 5);
        check({name, "_data"}, bus.out_data, exp);
        check({name, "_in_ready_low"}, bus.in_ready, 0);
        m_win = model_pick();
    endtask

    task automatic handshake(input string name);
        @(negedge clk);
        bus.out_ready = 1'b1;
        @(posedge clk); #1;
        check({name, "_drop_valid"}, bus.out_valid, 0);
        check({name, "_in_ready_up"}, bus.in_ready, 1);
        @(negedge clk);
        bus.out_ready = 1'b0;
    endtask

    typedef struct {
        string           name;
        logic [4:0][4:0] id;
        logic [4:0][7:0] sz;
        logic [4:0][7:0] iq;
        logic [4:0][7:0] eq;
        int              ws, wi, we;
        logic [7:0]      exp;
    } vec_t;

    vec_t vec[4];

    initial begin
        int eqv[5];
        logic [7:0] d0;
        bit ok;

        bus.in_valid = 1'b0; bus.out_ready = 1'b0;
        bus.doraemon_id = '0; bus.size = '0; bus.iq_score = '0; bus.eq_score = '0;
        bus.size_weight = '0; bus.iq_weight = '0; bus.eq_weight = '0;
        model_reset();

        eqv = '{10, 200, 50, 200, 0};
        for (int k = 0; k < 5; k++) begin
            vec[0].id[k] = 5'(k + 1);  vec[0].sz[k] = 8'(10 * (k + 1));
            vec[0].iq[k] = 8'd0;       vec[0].eq[k] = 8'd0;
            vec[1].id[k] = 5'(k + 7);  vec[1].sz[k] = 8'd20;
            vec[1].iq[k] = 8'd3;       vec[1].eq[k] = 8'd9;
            vec[2].id[k] = 5'(k + 15);
            vec[2].sz[k] = (k == 0) ? 8'd100 : (k == 2) ? 8'd255 : 8'd254;
            vec[2].iq[k] = vec[2].sz[k];
            vec[2].eq[k] = vec[2].sz[k];
            vec[3].id[k] = 5'(k + 20); vec[3].sz[k] = 8'd200;
            vec[3].iq[k] = 8'd50;      vec[3].eq[k] = 8'(eqv[k]);
        end
        vec[0].name = "ascend";  vec[0].ws = 1; vec[0].wi = 0; vec[0].we = 0; vec[0].exp = 8'h85;
        vec[1].name = "all_tie"; vec[1].ws = 2; vec[1].wi = 1; vec[1].we = 4; vec[1].exp = 8'h07;
        vec[2].name = "extreme"; vec[2].ws = 7; vec[2].wi = 7; vec[2].we = 7; vec[2].exp = 8'h51;
        vec[3].name = "eq_tie";  vec[3].ws = 0; vec[3].wi = 0; vec[3].we = 5; vec[3].exp = 8'h35;

        for (int v = 0; v < 4; v++) begin
            do_reset();
            for (int k = 0; k < 5; k++)
                send(vec[v].id[k], vec[v].sz[k], vec[v].iq[k], vec[v].eq[k],
                     vec[v].ws, vec[v].wi, vec[v].we);
            wait_result(vec[v].name, vec[v].exp);
            handshake(vec[v].name);
        end

        // Backpressure hold, single handshake, then refill of the winning door.
        do_reset();
        for (int k = 0; k < 5; k++) send(k + 1, 10 * (k + 1), 0, 0, 1, 0, 0);
        wait_result("hold_first", 8'h85);
        d0 = bus.out_data;
        ok = 1'b1;
        repeat (20) begin
            @(posedge clk); #1;
            if (!bus.out_valid || bus.out_data !== d0 || bus.in_ready) ok = 1'b0;
        end
        check("hold_stable", ok, 1);
        handshake("hold");
        ok = 1'b1;
        repeat (4) begin @(posedge clk); #1; if (bus.out_valid) ok = 1'b0; end
        check("no_duplicate", ok, 1);
        send(9, 0, 0, 0, 1, 0, 0);
        wait_result("refill", 8'h64);
        handshake("refill");

        // Candidates offered while not ready must be ignored, weights included.
        send(12, 200, 0, 0, 1, 0, 0);
        bus.doraemon_id = 5'd31; bus.size = 8'd255; bus.iq_score = 8'd255; bus.eq_score = 8'd255;
        bus.size_weight = 3'd7;  bus.iq_weight = 3'd7; bus.eq_weight = 3'd7;
        bus.in_valid = 1'b1;
        wait_result("ignore_busy", 8'h6C);
        repeat (3) @(posedge clk);
        #1;
        check("ignore_emit_data", bus.out_data, 8'h6C);
        @(negedge clk);
        bus.in_valid = 1'b0;
        handshake("ignore_busy");

        // One-cycle reset in the middle of evaluation discards the pending result.
        do_reset();
        for (int k = 0; k < 5; k++) send(k + 3, 250 - k, 7, 7, 3, 3, 3);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        model_reset();
        ok = 1'b1;
        repeat (10) begin @(posedge clk); #1; if (bus.out_valid) ok = 1'b0; end
        check("mid_eval_rst_no_valid", ok, 1);
        check("mid_eval_rst_busy", bus.busy, 0);
        check("mid_eval_rst_ready", bus.in_ready, 1);
        for (int k = 0; k < 5; k++) send(k + 1, 10 * (k + 1), 0, 0, 1, 0, 0);
        wait_result("after_rst", 8'h85);
        handshake("after_rst");

        // Randomized fills and refills against the reference model.
        for (int r = 0; r < 4; r++) begin
            do_reset();
            for (int k = 0; k < 5; k++)
                send($urandom_range(0, 31),
                     ($urandom_range(0, 1) != 0) ? $urandom_range(0, 255) : $urandom_range(0, 3) * 85,
                     $urandom_range(0, 255), $urandom_range(0, 3) * 85,
                     $urandom_range(0, 7), $urandom_range(0, 7), $urandom_range(0, 7));
            wait_result("rand_fill", model_data());
            handshake("rand_fill");
            for (int j = 0; j < 8; j++) begin
                send($urandom_range(0, 31),
                     $urandom_range(0, 3) * 85, $urandom_range(0, 255), $urandom_range(0, 255),
                     $urandom_range(0, 7), $urandom_range(0, 7), $urandom_range(0, 7));
                wait_result("rand_refill", model_data());
                repeat ($urandom_range(0, 3)) @(posedge clk);
                handshake("rand_refill");
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end
endmodule
